// File: rtl/axi_req_queue_pkg.sv
// Shared types and default widths for the AXI request queue.
// AXI_ADDR_W/AXI_DATA_W give the default address and data ranges.
package axi_req_queue_pkg;

  localparam int unsigned AXI_ADDR_W = 4;
  localparam int unsigned AXI_DATA_W = 8;
  localparam int unsigned AXI_RESP_W = 4;
  localparam int unsigned AXI_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    WAIT_B = 2'd3
  } state_e;

endpackage

// File: rtl/axi_req_fifo.sv
// In-order request FIFO with extra-MSB pointers for full/empty detection.
module axi_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Same index with differing wrap bit means the writer lapped the reader.
  assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = wdata;
      wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/axi_req_queue.sv
// Queues read/write requests and issues them one at a time to an AXI master.
// Optional completion counters are enabled by defining AXI_REQQ_STATS_EN.
module axi_req_queue
  import axi_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  read,
  output logic                  write,
  output logic [ADDR_W-1:0]     address_to_read,
  output logic [ADDR_W-1:0]     address_to_write,
  output logic [DATA_W-1:0]     data_to_write,
  input  logic                  AR_VALID,
  input  logic                  AW_VALID,
  input  logic                  R_VALID,
  input  logic                  R_READY,
  input  logic                  B_VALID,
  input  logic                  B_READY,
  input  logic [DATA_W-1:0]     data_read,
  input  logic [AXI_RESP_W-1:0] BRESPONSE,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [AXI_RESP_W-1:0] rsp_resp
`ifdef AXI_REQQ_STATS_EN
  ,
  output logic [AXI_CNT_W-1:0]  rd_done_cnt,
  output logic [AXI_CNT_W-1:0]  wr_done_cnt
`endif
);

  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

  logic [ENTRY_W-1:0]    head;
  logic                  head_write;
  logic [ADDR_W-1:0]     head_addr;
  logic [DATA_W-1:0]     head_wdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_c;

  state_e                state_q, state_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_rd_q, addr_rd_d;
  logic [ADDR_W-1:0]     addr_wr_q, addr_wr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic [AXI_RESP_W-1:0] rsp_resp_q, rsp_resp_d;

  // Address-channel valids are snooped but carry no information the FSM needs.
  logic unused_snoop;
  assign unused_snoop = AR_VALID ^ AW_VALID;

  axi_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .wdata ({req_write, req_addr, req_wdata}),
    .pop   (pop_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_write, head_addr, head_wdata} = head;
  assign req_ready = !fifo_full;

  always_comb begin
    state_d     = state_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    addr_rd_d   = addr_rd_q;
    addr_wr_d   = addr_wr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    pop_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          state_d = ISSUE;
          if (head_write) begin
            write_d   = 1'b1;
            addr_wr_d = head_addr;
            wdata_d   = head_wdata;
          end else begin
            read_d    = 1'b1;
            addr_rd_d = head_addr;
          end
        end
      end
      ISSUE: begin
        state_d = write_q ? WAIT_B : WAIT_R;
      end
      WAIT_R: begin
        if (R_VALID && R_READY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_data_d  = data_read;
          rsp_resp_d  = '0;
          state_d     = IDLE;
        end
      end
      WAIT_B: begin
        if (B_VALID && B_READY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_data_d  = '0;
          rsp_resp_d  = BRESPONSE;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_rd_q   <= '0;
      addr_wr_q   <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_rd_q   <= addr_rd_d;
      addr_wr_q   <= addr_wr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign read             = read_q;
  assign write            = write_q;
  assign address_to_read  = addr_rd_q;
  assign address_to_write = addr_wr_q;
  assign data_to_write    = wdata_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_write        = rsp_write_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_resp         = rsp_resp_q;

`ifdef AXI_REQQ_STATS_EN
  logic [AXI_CNT_W-1:0] rd_done_cnt_q, rd_done_cnt_d;
  logic [AXI_CNT_W-1:0] wr_done_cnt_q, wr_done_cnt_d;

  // Counters advance on the same edge that raises rsp_valid.
  always_comb begin
    rd_done_cnt_d = rd_done_cnt_q;
    wr_done_cnt_d = wr_done_cnt_q;
    if (rsp_valid_d && !rsp_write_d) rd_done_cnt_d = rd_done_cnt_q + AXI_CNT_W'(1);
    if (rsp_valid_d && rsp_write_d)  wr_done_cnt_d = wr_done_cnt_q + AXI_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_done_cnt_q <= '0;
      wr_done_cnt_q <= '0;
    end else begin
      rd_done_cnt_q <= rd_done_cnt_d;
      wr_done_cnt_q <= wr_done_cnt_d;
    end
  end

  assign rd_done_cnt = rd_done_cnt_q;
  assign wr_done_cnt = wr_done_cnt_q;
`endif

endmodule
